branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 124 ++++++++++++
 tb/tb_branch_predictor.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Branch predictor: direct-mapped BTB with a 2-bit saturating direction counter per entry.
// Latency: lookup is combinational from registered state; updates land on the next rising clk.
// Backpressure: none; updates are accepted every cycle, and stall only gates the optional statistics.
//
// Ports:
//   clk, reset           single clock, asynchronous active-high reset
//   lookup_pc            fetch PC to predict
//   BranchPredict        1 = predict taken
//   BranchTarget         predicted next fetch address (entry target, or lookup_pc+4)
//   upd_*                resolved-branch update from EX (valid, pc, taken, target, mispredict)
//   flush_all            invalidate every entry; wins over a same-cycle update
//   stall                pipeline stall, counts toward the statistics only
//   stat_lookups, stat_mispredicts   present only when BRANCH_PREDICTOR_STATS_EN is defined
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] lookup_pc,
    input  logic        stall,
    output logic        BranchPredict,
    output logic [31:0] BranchTarget,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    input  logic        flush_all
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    // Lookup path: purely combinational, so an update in flight is not visible yet.
    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[31:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign BranchPredict = lk_hit && cnt_q[lk_idx][1];
    assign BranchTarget  = BranchPredict ? target_q[lk_idx] : (lookup_pc + 32'd4);

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[31:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b00;
            end
        end else if (flush_all) begin
            // Only the valid bits are cleared; counters and targets are left stale.
            valid_q <= '0;
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_taken) begin
                    if (cnt_q[up_idx] != 2'b11) begin
                        cnt_q[up_idx] <= cnt_q[up_idx] + 2'd1;
                    end
                    target_q[up_idx] <= upd_target;
                end else if (cnt_q[up_idx] != 2'b00) begin
                    cnt_q[up_idx] <= cnt_q[up_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Taken miss evicts whatever shares the index, starting weakly taken.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                cnt_q[up_idx]    <= 2'b10;
            end
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] lookups_q;
    logic [31:0] mispredicts_q;

    // Counters ignore flush_all and wrap naturally at 2^32.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else begin
            if (!stall) begin
                lookups_q <= lookups_q + 32'd1;
            end
            if (upd_valid && upd_mispredict) begin
                mispredicts_q <= mispredicts_q + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispredicts_q;

    logic unused_ok;
    assign unused_ok = ^upd_pc[1:0];
`else
    // Byte-offset bits and the statistics-only inputs have no consumer in this build.
    logic unused_ok;
    assign unused_ok = ^{upd_pc[1:0], stall, upd_mispredict};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        stall;
    logic        BranchPredict;
    logic [31:0] BranchTarget;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        flush_all;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .lookup_pc      (lookup_pc),
        .stall          (stall),
        .BranchPredict  (BranchPredict),
        .BranchTarget   (BranchTarget),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .upd_mispredict (upd_mispredict),
        .flush_all      (flush_all)
`ifdef BRANCH_PREDICTOR_STATS_EN
        ,
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: one expected lookup response per cycle.
    bit          q_pred [$];
    logic [31:0] q_tgt  [$];
    string       q_name [$];

    // Reference model: table keyed by index, holding the architectural entry contents.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    logic [31:0] m_look;
    logic [31:0] m_mis;

    // Optional constant expectation that overrides the model for the next step.
    bit          k_use = 1'b0;
    bit          k_pred;
    logic [31:0] k_tgt;
    string       k_name;

    function automatic int midx(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic logic [31:0] mtag(input logic [31:0] pc);
        return pc >> (IDX_W + 2);
    endfunction

    task automatic model_predict(input logic [31:0] pc, output bit p, output logic [31:0] t);
        int i;
        i = midx(pc);
        p = m_valid[i] && (m_tag[i] == mtag(pc)) && (m_cnt[i] >= 2);
        t = p ? m_tgt[i] : pc + 32'd4;
    endtask

    // What the table should look like after the coming rising edge.
    task automatic model_update();
        int  i;
        bit  hit;
        if (reset) begin
            for (int j = 0; j < ENTRIES; j++) begin
                m_valid[j] = 1'b0;
                m_cnt[j]   = 0;
                m_tgt[j]   = 32'd0;
            end
            m_look = 32'd0;
            m_mis  = 32'd0;
        end else begin
            if (!stall) m_look = m_look + 32'd1;
            if (upd_valid && upd_mispredict) m_mis = m_mis + 32'd1;
            if (flush_all) begin
                for (int j = 0; j < ENTRIES; j++) m_valid[j] = 1'b0;
            end else if (upd_valid) begin
                i   = midx(upd_pc);
                hit = m_valid[i] && (m_tag[i] == mtag(upd_pc));
                if (hit) begin
                    if (upd_taken) begin
                        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
                        m_tgt[i] = upd_target;
                    end else begin
                        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = mtag(upd_pc);
                    m_tgt[i]   = upd_target;
                    m_cnt[i]   = 2;
                end
            end
        end
    endtask

    task automatic push_expect();
        bit          p;
        logic [31:0] t;
        model_predict(lookup_pc, p, t);
        if (k_use) begin
            p = k_pred;
            t = k_tgt;
        end
        q_pred.push_back(p);
        q_tgt.push_back(t);
        q_name.push_back(k_use ? k_name : "lookup");
        k_use = 1'b0;
    endtask

    task automatic expect_k(input string nm, input bit p, input logic [31:0] t);
        k_use  = 1'b1;
        k_name = nm;
        k_pred = p;
        k_tgt  = t;
    endtask

    // Called just after a rising edge: drive one cycle of inputs, record the expectation.
    task automatic step(input logic [31:0] pc, input bit uv, input logic [31:0] upc, input bit ut,
                        input logic [31:0] utgt, input bit um, input bit fl, input bit st);
        lookup_pc      = pc;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        flush_all      = fl;
        stall          = st;
        push_expect();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        step(pc, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic upd_look(input logic [31:0] pc, input logic [31:0] upc, input bit ut,
                            input logic [31:0] utgt);
        step(pc, 1'b1, upc, ut, utgt, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] rpc();
        logic [31:0] idx;
        logic [31:0] t;
        idx = $urandom_range(0, ENTRIES - 1);
        t   = $urandom_range(0, 2);
        return 32'h4000_0000 + t * 32'h100 + idx * 32'd4;
    endfunction

    // Monitor: compares the DUT response against the queued expectation mid-cycle.
    bit          mon_p;
    logic [31:0] mon_t;
    string       mon_n;
    always @(negedge clk) begin
        if (q_pred.size() > 0) begin
            mon_p = q_pred.pop_front();
            mon_t = q_tgt.pop_front();
            mon_n = q_name.pop_front();
            checks++;
            if (BranchPredict !== mon_p || BranchTarget !== mon_t) begin
                failures++;
                $display("FAIL %s: pc=%h got pred=%0b tgt=%h, want pred=%0b tgt=%h",
                         mon_n, lookup_pc, BranchPredict, BranchTarget, mon_p, mon_t);
            end
        end
    end

    initial begin
        reset = 1'b1;
        lookup_pc = 32'hBFC0_0010;
        stall = 1'b0; upd_valid = 1'b0; upd_pc = 32'd0; upd_taken = 1'b0;
        upd_target = 32'd0; upd_mispredict = 1'b0; flush_all = 1'b0;
        m_look = 32'd0; m_mis = 32'd0;
        for (int j = 0; j < ENTRIES; j++) begin
            m_valid[j] = 1'b0; m_tag[j] = 32'd0; m_tgt[j] = 32'd0; m_cnt[j] = 0;
        end
        @(posedge clk);
        #1;

        // Reset and cold predict
        expect_k("in_reset", 1'b0, 32'hBFC0_0014);
        look(32'hBFC0_0010);
        look(32'hBFC0_0010);
        reset = 1'b0;
        expect_k("cold_predict", 1'b0, 32'hBFC0_0014);
        look(32'hBFC0_0010);

        // Allocation: same-cycle lookup sees old contents, next cycle sees the new entry
        expect_k("alloc_same_cycle", 1'b0, 32'hBFC0_0024);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b1, 32'hBFC0_0100);
        expect_k("alloc_hit", 1'b1, 32'hBFC0_0100);
        look(32'hBFC0_0020);

        // Saturation at the top, then walk down and confirm the floor holds
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b1, 32'hBFC0_0100);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b1, 32'hBFC0_0100);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b0, 32'd0);
        expect_k("sat_hi_after_1nt", 1'b1, 32'hBFC0_0100);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b0, 32'd0);
        expect_k("sat_after_2nt", 1'b0, 32'hBFC0_0024);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b0, 32'd0);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b0, 32'd0);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b1, 32'hBFC0_0100);
        expect_k("sat_lo_after_1t", 1'b0, 32'hBFC0_0024);
        upd_look(32'hBFC0_0020, 32'hBFC0_0020, 1'b1, 32'hBFC0_0100);
        expect_k("sat_lo_after_2t", 1'b1, 32'hBFC0_0100);
        look(32'hBFC0_0020);

        // Aliasing on a shared index
        upd_look(32'hBFC0_0020, 32'hBFC0_0060, 1'b1, 32'hBFC0_0200);
        expect_k("alias_old_miss", 1'b0, 32'hBFC0_0024);
        look(32'hBFC0_0020);
        expect_k("alias_new_hit", 1'b1, 32'hBFC0_0200);
        look(32'hBFC0_0060);

        // Flush and allocating update in the same cycle
        expect_k("flush_cycle_old", 1'b1, 32'hBFC0_0200);
        step(32'hBFC0_0060, 1'b1, 32'hBFC0_0030, 1'b1, 32'hBFC0_0300, 1'b0, 1'b1, 1'b0);
        expect_k("flush_drops_upd", 1'b0, 32'hBFC0_0034);
        look(32'hBFC0_0030);
        expect_k("flush_clears", 1'b0, 32'hBFC0_0064);
        look(32'hBFC0_0060);

        // 32-bit wrap of the fall-through address
        expect_k("pc_wrap", 1'b0, 32'h0000_0000);
        look(32'hFFFF_FFFC);

        // Not-taken miss leaves the table alone
        upd_look(32'hBFC0_0070, 32'hBFC0_0070, 1'b0, 32'hDEAD_0000);
        expect_k("nt_miss_no_alloc", 1'b0, 32'hBFC0_0074);
        look(32'hBFC0_0070);

        // Asynchronous reset abandons an update in flight
        upd_look(32'hBFC0_0070, 32'hBFC0_0070, 1'b1, 32'h1111_0000);
        expect_k("pre_reset_hit", 1'b1, 32'h1111_0000);
        look(32'hBFC0_0070);
        lookup_pc = 32'hBFC0_0070; upd_valid = 1'b1; upd_pc = 32'hBFC0_0044;
        upd_taken = 1'b1; upd_target = 32'h2222_0000; upd_mispredict = 1'b1;
        flush_all = 1'b0; stall = 1'b0;
        #1;
        reset = 1'b1;
        expect_k("async_reset", 1'b0, 32'hBFC0_0074);
        push_expect();
        @(posedge clk);
        model_update();
        #1;
        reset = 1'b0;
        expect_k("reset_abandon", 1'b0, 32'hBFC0_0048);
        look(32'hBFC0_0044);
        for (int i = 0; i < 9; i++) begin
            step(32'hBFC0_0050, 1'b1, 32'hBFC0_0090, 1'b0, 32'd0, (i < 3), 1'b0, 1'b0);
        end
`ifdef BRANCH_PREDICTOR_STATS_EN
        checks++;
        if (stat_lookups !== 32'd10 || stat_mispredicts !== 32'd3) begin
            failures++;
            $display("FAIL stats_directed: got lookups=%0d mispredicts=%0d, want 10 3",
                     stat_lookups, stat_mispredicts);
        end
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 30) == 0) ? 32'hFFFF_FFFC : rpc();
            step(pc,
                 $urandom_range(0, 9) < 6,
                 rpc(),
                 $urandom_range(0, 9) < 6,
                 $urandom(),
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 3);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q_pred.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", q_pred.size());
        end
`ifdef BRANCH_PREDICTOR_STATS_EN
        checks++;
        if (stat_lookups !== m_look || stat_mispredicts !== m_mis) begin
            failures++;
            $display("FAIL stats_random: got %0d %0d, want %0d %0d",
                     stat_lookups, stat_mispredicts, m_look, m_mis);
        end
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
